// File: rtl/response_framer.sv
// response_framer: wraps length-FIFO/send-ring responses and acks in CRC16 host frames for the UART
module response_framer #(
  parameter int LEN_BITS = 8,
  parameter int MAX_PAYLOAD = 59,
  parameter logic [7:0] SYNC_BYTE = 8'h7e
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LEN_BITS-1:0] len_data,
  input  logic                len_empty,
  output logic                len_rd_en,
  input  logic [7:0]          ring_data,
  input  logic                ring_empty,
  output logic                ring_rd_en,
  input  logic [3:0]          rx_seq,
  input  logic                ack_req,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                err_oversize,
  output logic [15:0]         frame_count
);
  typedef enum logic [2:0] {IDLE, LEN, SEQ, PAYLOAD, CRC_HI, CRC_LO, SYNC, DISCARD} state_t;
  state_t r_state, w_next;
  logic [LEN_BITS-1:0] r_n, r_cnt;
  logic [3:0] r_seq;
  logic [15:0] r_crc, r_frames;
  logic [7:0] r_byte;
  logic r_ack_pending, r_have, r_err;
  logic w_xfer, w_oversize;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] x;
    x = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) x = x[0] ? (x >> 1) ^ 16'h8408 : x >> 1;
    return x;
  endfunction

  assign w_oversize = int'(len_data) > MAX_PAYLOAD;
  assign w_xfer = tx_valid && tx_ready;
  assign busy = r_state != IDLE;
  assign err_oversize = r_err;
  assign frame_count = r_frames;

  always_comb begin
    w_next = r_state;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    len_rd_en = 1'b0;
    ring_rd_en = 1'b0;
    case (r_state)
      IDLE: begin
        len_rd_en = !len_empty && rst_n;
        w_next = !len_empty ? (w_oversize ? DISCARD : LEN) : (r_ack_pending ? LEN : IDLE);
      end
      LEN: begin
        tx_valid = 1'b1;
        tx_data = 8'(r_n) + 8'd5;
        w_next = tx_ready ? SEQ : LEN;
      end
      SEQ: begin
        tx_valid = 1'b1;
        tx_data = {4'h1, r_seq};
        w_next = tx_ready ? (r_n != '0 ? PAYLOAD : CRC_HI) : SEQ;
      end
      PAYLOAD: begin
        tx_valid = r_have;
        tx_data = r_byte;
        ring_rd_en = !r_have && !ring_empty && r_cnt != '0;
        w_next = (w_xfer && r_cnt == '0) ? CRC_HI : PAYLOAD;
      end
      CRC_HI: begin
        tx_valid = 1'b1;
        tx_data = r_crc[15:8];
        w_next = tx_ready ? CRC_LO : CRC_HI;
      end
      CRC_LO: begin
        tx_valid = 1'b1;
        tx_data = r_crc[7:0];
        w_next = tx_ready ? SYNC : CRC_LO;
      end
      SYNC: begin
        tx_valid = 1'b1;
        tx_data = SYNC_BYTE;
        w_next = tx_ready ? IDLE : SYNC;
      end
      default: begin
        // r_have doubles as "popped last cycle" so the FWFT head settles between pops
        ring_rd_en = !r_have && !ring_empty && r_cnt != '0;
        w_next = r_cnt == '0 ? IDLE : DISCARD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n <= '0;
      r_cnt <= '0;
      r_seq <= 4'h0;
      r_crc <= 16'hffff;
      r_frames <= 16'h0000;
      r_byte <= 8'h00;
      r_ack_pending <= 1'b0;
      r_have <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ack_pending <= ack_req || (r_ack_pending && !(r_state == SEQ && w_xfer));
      r_have <= ring_rd_en || (r_have && !w_xfer && r_state == PAYLOAD);
      if (len_rd_en) begin
        r_n <= len_data;
        r_cnt <= len_data;
        if (w_oversize) r_err <= 1'b1;
      end else if (r_state == IDLE && r_ack_pending) begin
        r_n <= '0;
        r_cnt <= '0;
      end
      if (ring_rd_en) begin
        r_cnt <= r_cnt - 1'b1;
        r_byte <= ring_data;
      end
      if (r_state == LEN && w_xfer) r_seq <= rx_seq;
      if (w_xfer && (r_state == LEN || r_state == SEQ || r_state == PAYLOAD)) r_crc <= crc_upd(r_crc, tx_data);
      if (r_state == SYNC && w_xfer) begin
        r_crc <= 16'hffff;
        r_frames <= r_frames + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_response_framer.sv
// tb_response_framer: scoreboard bench for response_framer with FWFT FIFO models
module tb_response_framer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] len_data, ring_data, tx_data;
  logic len_empty, ring_empty, len_rd_en, ring_rd_en;
  logic [3:0] rx_seq = 4'h0;
  logic ack_req = 1'b0;
  logic tx_ready = 1'b0;
  logic tx_valid, busy, err_oversize;
  logic [15:0] frame_count;
  logic [7:0] lq[$], rq[$], exp_q[$];
  int checks = 0, passes = 0, lpops = 0, rpops = 0;
  logic lp = 1'b0, rp = 1'b0, pv = 1'b0;
  logic [7:0] pd, e;

  response_framer dut (
    .clk(clk), .rst_n(rst_n), .len_data(len_data), .len_empty(len_empty), .len_rd_en(len_rd_en),
    .ring_data(ring_data), .ring_empty(ring_empty), .ring_rd_en(ring_rd_en), .rx_seq(rx_seq),
    .ack_req(ack_req), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .err_oversize(err_oversize), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mcrf(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r = {1'b0, r[15:1]};
      if (fb) r = r ^ 16'h8408;
    end
    return r;
  endfunction

  task automatic upd();
    len_empty = lq.size() == 0;
    len_data = len_empty ? 8'h00 : lq[0];
    ring_empty = rq.size() == 0;
    ring_data = ring_empty ? 8'h00 : rq[0];
  endtask

  task automatic sync_in();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] n, input logic [3:0] s, input logic [7:0] p[$]);
    logic [15:0] c;
    logic [7:0] b;
    c = 16'hffff;
    b = n + 8'd5;
    c = mcrf(c, b);
    exp_q.push_back(b);
    b = {4'h1, s};
    c = mcrf(c, b);
    exp_q.push_back(b);
    foreach (p[i]) begin
      c = mcrf(c, p[i]);
      exp_q.push_back(p[i]);
    end
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
    exp_q.push_back(8'h7e);
  endtask

  task automatic wait_fc(input logic [15:0] t, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_count === t) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Scoreboard consumer and handshake monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
      lp = 1'b0;
      rp = 1'b0;
    end else begin
      if (pv) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== pd) $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", tx_valid, tx_data, pd);
        else passes++;
      end
      pv = tx_valid && !tx_ready;
      pd = tx_data;
      if (tx_valid && tx_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL tx_byte: unexpected byte %h, required none", tx_data);
        else begin
          e = exp_q.pop_front();
          if (tx_data !== e) $display("FAIL tx_byte: got %h, required %h", tx_data, e);
          else passes++;
        end
      end
      if ((len_rd_en && len_empty) || (ring_rd_en && ring_empty)) begin
        checks++;
        $display("FAIL pop_empty: len_rd_en=%b ring_rd_en=%b while empty, required 0", len_rd_en, ring_rd_en);
      end
      lp = len_rd_en;
      rp = ring_rd_en;
    end
  end

  always @(posedge clk) begin
    #1;
    if (lp && lq.size() != 0) begin
      void'(lq.pop_front());
      lpops++;
    end
    if (rp && rq.size() != 0) begin
      void'(rq.pop_front());
      rpops++;
    end
    lp = 1'b0;
    rp = 1'b0;
    upd();
  end

  task automatic test_reset();
    logic [7:0] s[9];
    logic [15:0] c;
    upd();
    repeat (3) sync_in();
    checks++;
    if ({tx_valid, busy, len_rd_en, ring_rd_en, err_oversize, tx_data, frame_count} !== '0)
      $display("FAIL reset_outputs: valid=%b busy=%b len_rd=%b ring_rd=%b err=%b data=%h fc=%0d, required all 0",
               tx_valid, busy, len_rd_en, ring_rd_en, err_oversize, tx_data, frame_count);
    else passes++;
    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    c = 16'hffff;
    foreach (s[i]) c = mcrf(c, s[i]);
    checks++;
    if (c !== 16'h6f91) $display("FAIL crc_model: got %h, required 6f91", c);
    else passes++;
    rst_n = 1'b1;
    sync_in();
  endtask

  task automatic test_basic();
    logic [7:0] p[$];
    bit ok;
    sync_in();
    lpops = 0;
    rpops = 0;
    rx_seq = 4'h2;
    tx_ready = 1'b1;
    p = '{8'h01, 8'h02, 8'h03};
    push_frame(8'd3, 4'h2, p);
    foreach (p[i]) rq.push_back(p[i]);
    lq.push_back(8'd3);
    upd();
    wait_fc(16'd1, 200, ok);
    checks++;
    if (!ok) $display("FAIL basic_done: frame_count=%0d, required 1", frame_count); else passes++;
    checks++;
    if (lpops != 1 || rpops != 3) $display("FAIL basic_pops: len=%0d ring=%0d, required 1 and 3", lpops, rpops); else passes++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL basic_bytes: %0d bytes missing, required 0", exp_q.size()); else passes++;
  endtask

  task automatic test_ack();
    logic [7:0] p[$];
    logic [15:0] fc0;
    bit ok;
    sync_in();
    fc0 = frame_count;
    p.delete();
    rx_seq = 4'h5;
    ack_req = 1'b1;
    push_frame(8'd0, 4'h5, p);
    sync_in();
    ack_req = 1'b0;
    wait_fc(fc0 + 16'd1, 200, ok);
    checks++;
    if (!ok) $display("FAIL ack_done: frame_count=%0d, required %0d", frame_count, fc0 + 16'd1); else passes++;
    repeat (10) @(negedge clk);
    checks++;
    if (frame_count !== fc0 + 16'd1 || dut.r_ack_pending !== 1'b0)
      $display("FAIL ack_clear: fc=%0d pending=%b, required fc=%0d pending=0", frame_count, dut.r_ack_pending, fc0 + 16'd1);
    else passes++;
  endtask

  task automatic test_backpressure();
    logic [7:0] p[$];
    logic [15:0] fc0;
    sync_in();
    fc0 = frame_count;
    lpops = 0;
    rpops = 0;
    rx_seq = 4'h2;
    p = '{8'h01, 8'h02, 8'h03};
    push_frame(8'd3, 4'h2, p);
    foreach (p[i]) rq.push_back(p[i]);
    lq.push_back(8'd3);
    upd();
    for (int i = 0; i < 400 && frame_count !== fc0 + 16'd1; i++) begin
      tx_ready = (i % 10 < 6) ? i[0] : 1'b0;
      sync_in();
    end
    tx_ready = 1'b1;
    checks++;
    if (frame_count !== fc0 + 16'd1) $display("FAIL bp_done: frame_count=%0d, required %0d", frame_count, fc0 + 16'd1); else passes++;
    checks++;
    if (lpops != 1 || rpops != 3) $display("FAIL bp_pops: len=%0d ring=%0d, required 1 and 3", lpops, rpops); else passes++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL bp_bytes: %0d bytes missing, required 0", exp_q.size()); else passes++;
  endtask

  task automatic test_underflow();
    logic [7:0] p[$];
    logic [15:0] fc0;
    bit ok;
    sync_in();
    fc0 = frame_count;
    rpops = 0;
    rx_seq = 4'h3;
    p = '{8'ha5, 8'h5a};
    push_frame(8'd2, 4'h3, p);
    lq.push_back(8'd2);
    upd();
    repeat (14) sync_in();
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b1 || rpops != 0)
      $display("FAIL underflow_stall: valid=%b busy=%b pops=%0d, required valid=0 busy=1 pops=0", tx_valid, busy, rpops);
    else passes++;
    foreach (p[i]) rq.push_back(p[i]);
    upd();
    wait_fc(fc0 + 16'd1, 200, ok);
    checks++;
    if (!ok || exp_q.size() != 0) $display("FAIL underflow_done: fc=%0d left=%0d, required fc=%0d left=0", frame_count, exp_q.size(), fc0 + 16'd1);
    else passes++;
  endtask

  task automatic test_oversize();
    logic [7:0] p[$];
    logic [15:0] fc0;
    bit ok;
    sync_in();
    fc0 = frame_count;
    lpops = 0;
    rpops = 0;
    checks++;
    if (err_oversize !== 1'b0) $display("FAIL err_before: got %b, required 0", err_oversize); else passes++;
    rx_seq = 4'h7;
    for (int i = 0; i < 60; i++) rq.push_back(8'(i + 8'h40));
    rq.push_back(8'hc3);
    lq.push_back(8'd60);
    lq.push_back(8'd1);
    p = '{8'hc3};
    push_frame(8'd1, 4'h7, p);
    upd();
    wait_fc(fc0 + 16'd1, 2000, ok);
    checks++;
    if (!ok) $display("FAIL oversize_done: frame_count=%0d, required %0d", frame_count, fc0 + 16'd1); else passes++;
    repeat (10) @(negedge clk);
    checks++;
    if (err_oversize !== 1'b1) $display("FAIL err_sticky: got %b, required 1", err_oversize); else passes++;
    checks++;
    if (lpops != 2 || rpops != 61 || frame_count !== fc0 + 16'd1)
      $display("FAIL oversize_pops: len=%0d ring=%0d fc=%0d, required 2 61 %0d", lpops, rpops, frame_count, fc0 + 16'd1);
    else passes++;
  endtask

  task automatic test_simultaneous();
    logic [7:0] p[$];
    logic [15:0] fc0;
    bit ok;
    sync_in();
    fc0 = frame_count;
    rx_seq = 4'h9;
    p = '{8'h44};
    push_frame(8'd1, 4'h9, p);
    rq.push_back(8'h44);
    lq.push_back(8'd1);
    upd();
    ack_req = 1'b1;
    sync_in();
    ack_req = 1'b0;
    wait_fc(fc0 + 16'd1, 200, ok);
    repeat (20) @(negedge clk);
    checks++;
    if (!ok || frame_count !== fc0 + 16'd1 || dut.r_ack_pending !== 1'b0)
      $display("FAIL simul_single: fc=%0d pending=%b, required fc=%0d pending=0", frame_count, dut.r_ack_pending, fc0 + 16'd1);
    else passes++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] p[$];
    sync_in();
    rx_seq = 4'h1;
    p = '{8'h11, 8'h22, 8'h33};
    push_frame(8'd3, 4'h1, p);
    rq.push_back(8'h11);
    lq.push_back(8'd3);
    upd();
    repeat (12) sync_in();
    checks++;
    if (busy !== 1'b1 || tx_valid !== 1'b0) $display("FAIL mid_stall: busy=%b valid=%b, required 1 0", busy, tx_valid); else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_valid, busy, len_rd_en, ring_rd_en, err_oversize, tx_data, frame_count} !== '0)
      $display("FAIL async_reset: valid=%b busy=%b data=%h fc=%0d err=%b, required all 0", tx_valid, busy, tx_data, frame_count, err_oversize);
    else passes++;
    exp_q.delete();
    rq.delete();
    upd();
    repeat (3) sync_in();
    rst_n = 1'b1;
    repeat (5) sync_in();
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) $display("FAIL post_reset_idle: busy=%b valid=%b, required 0 0", busy, tx_valid); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ack();
    test_backpressure();
    test_underflow();
    test_oversize();
    test_simultaneous();
    test_reset_mid();
    test_basic();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/response_framer.md
Name: response_framer

Overview:
- Downstream consumer of the command unit's send side.
- Pops one response length from the length FIFO and the matching payload bytes from the send ring buffer.
- Wraps them in a host-protocol frame: length, sequence, payload, CRC16 (two bytes), sync byte.
- Streams the frame bytewise to the UART transmitter. Also emits empty ack frames on request from the receive side.

Parameters:
LEN_BITS, 8, width of length FIFO entries
MAX_PAYLOAD, 59, largest legal payload in bytes (frame max 64)
SYNC_BYTE, 8'h7e, frame terminator

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active low
len_data  in  LEN_BITS  head of length FIFO (first-word-fall-through), payload byte count
len_empty  in  1  length FIFO empty
len_rd_en  out  1  pop length FIFO, one-cycle pulse
ring_data  in  8  head of send ring (FWFT)
ring_empty  in  1  send ring empty
ring_rd_en  out  1  pop send ring, one-cycle pulse
rx_seq  in  4  next expected host sequence, from receive side
ack_req  in  1  one-cycle pulse: host frame accepted, ack needed
tx_data  out  8  byte to UART transmitter
tx_valid  out  1  tx_data valid
tx_ready  in  1  transmitter accepts byte this cycle
busy  out  1  frame in progress
err_oversize  out  1  sticky: length entry > MAX_PAYLOAD seen
frame_count  out  16  frames sent, wraps

Behaviour:
- Interface decided: one clock clk; reset rst_n asynchronous, active low.
- Reset values: all outputs 0, state IDLE, ack_pending 0, crc 16'hffff.
- Transfer rules:
  - A byte transfers on a cycle with tx_valid && tx_ready.
  - While tx_valid && !tx_ready, tx_data is held stable and tx_valid stays high.
  - At most one byte is presented per cycle.
- Pops:
  - len_rd_en and ring_rd_en are never asserted while the corresponding empty input is high.
  - They are single-cycle pulses; the next FWFT word is not sampled in the cycle following a pop.
- ack_pending:
  - Set by ack_req.
  - Cleared when any frame's seq byte transfers, since every frame carries the ack.
  - ack_req coinciding with that clear leaves ack_pending set.
- States:
  - IDLE:
    - If !len_empty: latch n = len_data, pulse len_rd_en, go LEN.
    - Else if ack_pending: n = 0, go LEN.
    - The length FIFO has priority over a pending ack.
  - LEN: present n+5 (8-bit); crc update on transfer; go SEQ.
  - SEQ:
    - Present {4'h1, rx_seq}, with rx_seq sampled on entry to SEQ.
    - crc update on transfer.
    - Go PAYLOAD if n != 0, else CRC_HI.
  - PAYLOAD:
    - When !ring_empty, pop a byte and present it; crc update on transfer.
    - After n bytes go CRC_HI.
    - If the ring is empty: tx_valid low, stall; no timeout.
  - CRC_HI: present crc[15:8]. CRC_LO: present crc[7:0]. SYNC: present SYNC_BYTE.
  - After the sync byte transfers: frame_count += 1, crc reset to ffff, go IDLE.
  - Minimum gap between the sync byte and the next len byte is 1 cycle.
- CRC:
  - CRC-16/MCRF4XX: reflected poly 0x8408, init ffff, no final xor, one byte per cycle.
  - Covers len, seq and payload. Check value 0x6F91 for ASCII "123456789".
- Oversize entry (n > MAX_PAYLOAD, or n+5 overflowing 8 bits):
  - Set err_oversize.
  - State DISCARD pops n ring bytes (stalling on empty) and emits nothing.
  - Return to IDLE; frame_count unchanged.
- busy is high in every state except IDLE.
- rst_n assertion mid-frame aborts immediately: tx_valid drops asynchronously and the partial frame is not completed. Any unpopped ring bytes of that frame remain and must be flushed by the system reset of the ring itself.

Test Plan:
- Length FIFO entry 3, ring bytes 01 02 03, rx_seq=2, tx_ready=1:
  - tx bytes 08 12 01 02 03 crcH crcL 7e, CRC matching the software model.
  - len_rd_en 1 pulse, ring_rd_en 3 pulses, frame_count=1.
- ack_req pulse with FIFOs empty, rx_seq=5: frame 05 15 crcH crcL 7e; ack_pending cleared after the seq byte.
- Backpressure:
  - Repeat the first scenario with tx_ready toggling 1/0 every cycle, plus 4-cycle low bursts.
  - Byte sequence identical; tx_data stable during stalls; no extra pops.
- Ring underflow: entry 2 with ring empty for 10 cycles after the seq byte, then 2 bytes arrive → tx_valid low meanwhile, frame completes correctly.
- Oversize: entry 60 followed by entry 1 → err_oversize=1, 60 ring bytes discarded with no tx output, then a correct 6-byte-length frame, frame_count=1.
- Simultaneous ack_req and non-empty length FIFO: one data frame only, ack_pending clear afterwards. rst_n low mid-PAYLOAD: all outputs 0 asynchronously, IDLE after release.
